// File: rtl/encoder_8to3_seq_pkg.sv
// encoder_pkg: shared widths, FSM state type and bit-scan helpers for the
// sequential 8-to-3 encoder (encoder_8to3_seq).
package encoder_pkg;

  localparam int ENC_IN_W   = 8;
  localparam int ENC_CODE_W = 3;
  // Wide enough to hold a popcount of ENC_IN_W bits (0..8).
  localparam int ENC_CNT_W  = 4;

  // IDLE accepts a new vector; SCAN emits one code per output handshake.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index of the lowest set bit; bit 0 has the highest priority.
  // Returns 0 for an all-zero vector (callers gate with a nonzero check).
  function automatic logic [ENC_CODE_W-1:0] lowest_set_idx(
    input logic [ENC_IN_W-1:0] vec
  );
    logic [ENC_CODE_W-1:0] idx;
    idx = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = ENC_IN_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = ENC_CODE_W'(i);
    end
    return idx;
  endfunction

  // Number of set bits in a request vector.
  function automatic logic [ENC_CNT_W-1:0] popcount8(
    input logic [ENC_IN_W-1:0] vec
  );
    logic [ENC_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      cnt = cnt + {{(ENC_CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder_8to3_seq_prio_enc.sv
// prio_enc_8to3: combinational lowest-set-bit encoder over the pending
// vector. Besides the code it flags when exactly one bit remains, which the
// top level uses both as out_last and as the "leave SCAN" condition.
module prio_enc_8to3
  import encoder_pkg::*;
(
  input  logic [ENC_IN_W-1:0]   vec,
  output logic [ENC_CODE_W-1:0] code,
  output logic                  one_left
);

  logic [ENC_IN_W-1:0] vec_minus_one;

  // Code of the lowest set bit, and "single bit" via the x & (x-1) trick.
  always_comb begin
    code          = lowest_set_idx(vec);
    vec_minus_one = vec - ENC_IN_W'(1);
    one_left      = (vec != '0) && ((vec & vec_minus_one) == '0);
  end

endmodule

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: accepts an 8-bit multi-hot vector over valid/ready and
// emits the 3-bit index of each set bit, lowest index first, one per output
// handshake.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in SCAN and, once high, out_code/out_last stay stable until the
// transfer completes.
//
// Build option: define ENC_POPCOUNT_EN to add out_count, the popcount of the
// accepted vector, registered at acceptance and held through the scan.
//
// All outputs derive from registered state (state, pending, zero flag,
// count); in_vec only reaches flops, never an output directly.
module encoder_8to3_seq
  import encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ENC_IN_W-1:0]   in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ENC_CODE_W-1:0] out_code,
  output logic                  out_last,
  output logic                  zero_vec
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [ENC_CNT_W-1:0]  out_count
`endif
);

  // FSM state is kept in a plainly named signal so checkers can bind to it.
  state_t                state;
  state_t                state_nxt;
  logic [ENC_IN_W-1:0]   pending;
  logic [ENC_IN_W-1:0]   pending_nxt;
  logic [ENC_IN_W-1:0]   clr_mask;
  logic [ENC_CODE_W-1:0] code;
  logic                  one_left;
  logic                  accept;

  prio_enc_8to3 u_prio_enc (
    .vec      (pending),
    .code     (code),
    .one_left (one_left)
  );

  // A vector is taken on any in_valid edge while idle, zero or not.
  assign accept = in_valid && (state == IDLE);

  // State and pending-bit registers; reset drops any partial scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Next-state, pending update and handshake outputs.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    clr_mask    = '0;
    clr_mask[code] = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        // Zero vectors are consumed here without leaving IDLE.
        if (in_valid && (in_vec != '0)) begin
          pending_nxt = in_vec;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        // in_valid/in_vec are deliberately ignored here.
        if (out_ready) begin
          pending_nxt = pending & ~clr_mask;
          if (one_left) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // Code and last flag come straight from the registered pending bits.
  always_comb begin
    out_code = code;
    out_last = out_valid && one_left;
  end

  // One-cycle pulse in the cycle after a zero vector is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_vec <= 1'b0;
    end else begin
      zero_vec <= accept && (in_vec == '0);
    end
  end

`ifdef ENC_POPCOUNT_EN
  // Popcount captured at acceptance; zero vectors load 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (accept) begin
      out_count <= popcount8(in_vec);
    end
  end
`else
  // Without the popcount option there is no count state at all.
`endif

endmodule

// File: doc/encoder_8to3_seq.md
# encoder_8to3_seq

Sequential 8-to-3 encoder: the reverse direction of the 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake, then emits the 3-bit index of every set bit, one per output handshake, lowest index first. Downstream logic uses it to turn multi-hot line vectors back into binary codes.

## Interface
Parameters:
- none; widths are fixed at 8 inputs and 3 code bits (constants in package).

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer presents in_vec
- in_ready  output  1  block can accept a vector (high only in IDLE)
- in_vec  input  8  request vector; bit i set means emit code i
- out_valid  output  1  out_code is valid
- out_ready  input  1  consumer accepts out_code
- out_code  output  3  binary index of the lowest pending bit
- out_last  output  1  high with out_valid when this is the final code of the vector
- zero_vec  output  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- State machine: IDLE, SCAN.
- IDLE: in_ready=1. On in_valid && in_ready:
  - in_vec != 0: load pending <= in_vec, go to SCAN.
  - in_vec == 0: stay in IDLE, pulse zero_vec next cycle, emit nothing.
- SCAN: in_ready=0, out_valid=1, out_code=index of lowest set bit of pending, out_last=1 iff exactly one bit is pending.
  - On out_valid && out_ready: clear that bit. If it was the last bit, go to IDLE; otherwise stay in SCAN.
  - Without out_ready: pending, out_code and out_last are held stable.
- in_valid is ignored while in SCAN, and in_vec is not sampled then.
- Priority is fixed: bit 0 is highest, bit 7 lowest.
- Reset (asserted at any time, including mid-SCAN): returns to IDLE and drops pending bits; no partial output is resumed.

## Timing
- Reset values: out_valid=0, out_code=0, out_last=0, zero_vec=0, pending=0, state=IDLE. in_ready=1 once rst_n deasserts.
- Latency: vector accepted at edge t; first out_valid at cycle t+1.
- With out_ready held high, one code is emitted per cycle. The last handshake at edge u gives in_ready=1 at cycle u+1.
- Throughput: popcount(in_vec)+1 cycles per nonzero vector, and 1 cycle per zero vector.
- out_code and out_last are registered or derived from registered pending only; there is no combinational path from in_vec to the outputs.
- zero_vec is high for exactly the cycle after acceptance.

## Configuration
- ENC_POPCOUNT_EN defined:
  - Adds output out_count [3:0], holding the popcount of the vector, registered at acceptance.
  - out_count is stable through the whole SCAN, is valid from cycle t+1, and resets to 0.
  - For a zero vector, out_count=0 in the zero_vec cycle.
- ENC_POPCOUNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package encoder_pkg:
  - ENC_IN_W=8 and ENC_CODE_W=3.
  - State enum {IDLE, SCAN}.
  - Function lowest_set_idx(8-bit) returning 3 bits.
- Sub-module prio_enc_8to3: combinational lowest-set-bit encoder that also outputs a "one bit left" flag. It is instantiated once on pending.
- Top level: FSM, pending register, handshake logic, optional popcount.

## Test plan
- Reset mid-operation:
  - Accept 8'b1111_1111, emit 3 codes, assert rst_n=0 asynchronously mid-cycle.
  - Required: outputs return to reset values immediately; after release, in_ready=1 and no stale code appears.
- Simple vector, no stall:
  - in_vec=8'b1010_0100, out_ready=1.
  - Required: codes 2, 5, 7 on cycles t+1..t+3, out_last only with 7, in_ready=1 at t+4.
- Backpressure:
  - in_vec=8'b0000_0011, out_ready=0 for 4 cycles, then 1.
  - Required: out_code=0 held stable with out_last=0, then codes 0 and 1 (out_last with 1).
- Zero and single vectors:
  - in_vec=8'h00: zero_vec pulse for exactly one cycle, out_valid never high.
  - in_vec=8'h80: single code 7 with out_last=1.
- in_valid during SCAN:
  - Hold in_valid=1 with a changing in_vec while emitting codes.
  - Required: in_ready=0 throughout, and only the original vector's codes are emitted.
  - The next vector is accepted the cycle after the last handshake.
- ENC_POPCOUNT_EN build:
  - in_vec=8'b0111_0110.
  - Required: out_count=5 from t+1 through the end of SCAN; in_vec=0 gives out_count=0.
